// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register file write port between the ALU (req0)
//               and the load/store unit (req1). Alternates grants when both
//               requesters contend. Registers the winning request onto the
//               write port with one cycle of latency. Keeps a busy
//               scoreboard of destinations that have outstanding writes.
// Ports       : clk, reset (async, active-low)
//               req0_valid/rd/wd -> req0_ready    ALU writeback
//               req1_valid/rd/wd -> req1_ready    LSU writeback
//               issue_valid/rd                    marks a destination busy
//               rf_we/rf_rd/rf_wd                 register file write port
//               busy[2**AW]                       outstanding-write scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [AW-1:0]     req0_rd,
    input  logic [XLEN-1:0]   req0_wd,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [AW-1:0]     req1_rd,
    input  logic [XLEN-1:0]   req1_wd,
    output logic              req1_ready,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              rf_we,
    output logic [AW-1:0]     rf_rd,
    output logic [XLEN-1:0]   rf_wd,
    output logic [2**AW-1:0]  busy
);

    localparam int NREG = 2**AW;

    // Index of the requester that won the most recent transfer.
    logic              r_last_grant;
    logic              r_we;
    logic [AW-1:0]     r_rd;
    logic [XLEN-1:0]   r_wd;
    logic [NREG-1:0]   r_busy;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;
    logic [AW-1:0]     w_sel_rd;
    logic [XLEN-1:0]   w_sel_wd;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_clr_mask;

    // Under contention the requester that did not win last time goes next.
    // Each ready depends only on the two valids and the last grant.
    assign w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
    assign w_xfer = w_gnt0 || w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_sel_rd = w_gnt1 ? req1_rd : req0_rd;
    assign w_sel_wd = w_gnt1 ? req1_wd : req0_wd;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (issue_valid) begin
            w_set_mask[issue_rd] = 1'b1;
        end
        if (r_we) begin
            w_clr_mask[r_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_rd         <= '0;
            r_wd         <= '0;
            r_busy       <= '0;
        end else begin
            // Writes to x0 are accepted but never reach the register file.
            r_we <= w_xfer && (w_sel_rd != '0);
            if (w_xfer) begin
                r_last_grant <= w_gnt1;
                r_rd         <= w_sel_rd;
                r_wd         <= w_sel_wd;
            end
            // Clear before set so that a newly issued write to the register
            // being retired this cycle keeps it busy. Bit 0 is never busy.
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~{{(NREG-1){1'b0}}, 1'b1};
        end
    end

    assign rf_we = r_we;
    assign rf_rd = r_rd;
    assign rf_wd = r_wd;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A behavioural
//               model tracks grant order, the pending write and the busy set.
//               It is compared on every falling edge. Directed vectors add
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            reset;
    logic            req0_valid;
    logic [AW-1:0]   req0_rd;
    logic [XLEN-1:0] req0_wd;
    logic            req0_ready;
    logic            req1_valid;
    logic [AW-1:0]   req1_rd;
    logic [XLEN-1:0] req1_wd;
    logic            req1_ready;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [31:0]     busy;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_rd     (req0_rd),
        .req0_wd     (req0_wd),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_rd     (req1_rd),
        .req1_wd     (req1_wd),
        .req1_ready  (req1_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wd       (rf_wd),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_last;    // 1 means req1 was served most recently
    bit              m_we;
    logic [AW-1:0]   m_rd;
    logic [XLEN-1:0] m_wd;
    bit   [31:0]     m_busy;
    int              m_g;
    int              c_g;

    // -1: nobody served, 0: req0, 1: req1
    function automatic int model_grant();
        if (req0_valid && req1_valid) return m_last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_last = 1'b1;
            m_we   = 1'b0;
            m_rd   = '0;
            m_wd   = '0;
            m_busy = '0;
        end else begin
            m_g = model_grant();
            if (m_we) m_busy[m_rd] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (m_g == 0) begin
                m_we = (req0_rd != 0); m_rd = req0_rd; m_wd = req0_wd; m_last = 1'b0;
            end else if (m_g == 1) begin
                m_we = (req1_rd != 0); m_rd = req1_rd; m_wd = req1_wd; m_last = 1'b1;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        c_g = model_grant();
        chk("m_req0_ready", req0_ready, c_g == 0);
        chk("m_req1_ready", req1_ready, c_g == 1);
        chk("m_both_ready", req0_ready && req1_ready, 0);
        chk("m_rf_we", rf_we, m_we);
        if (m_we) begin
            chk("m_rf_rd", rf_rd, m_rd);
            chk("m_rf_wd", rf_wd, m_wd);
        end
        chk("m_busy", busy, m_busy);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req0_valid = 0; req0_rd = 0; req0_wd = 0;
        req1_valid = 0; req1_rd = 0; req1_wd = 0;
        issue_valid = 0; issue_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;

        // Single ALU writeback
        req0_valid = 1; req0_rd = 5; req0_wd = 32'hDEADBEEF;
        #1;
        chk("t1_req0_ready", req0_ready, 1);
        chk("t1_req1_ready", req1_ready, 0);
        step(); idle();
        chk("t1_rf_we", rf_we, 1);
        chk("t1_rf_rd", rf_rd, 5);
        chk("t1_rf_wd", rf_wd, 32'hDEADBEEF);
        step();
        chk("t1_rf_we_off", rf_we, 0);

        // Write to x0 is accepted but suppressed (also makes req1 last)
        req1_valid = 1; req1_rd = 0; req1_wd = 32'hFFFFFFFF;
        #1;
        chk("t3_req1_ready", req1_ready, 1);
        step(); idle();
        chk("t3_rf_we", rf_we, 0);

        // Continuous contention alternates starting with req0
        req0_valid = 1; req0_rd = 1; req0_wd = 32'h11;
        req1_valid = 1; req1_rd = 2; req1_wd = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_req0_ready", req0_ready, (i % 2) == 0);
            chk("t2_req1_ready", req1_ready, (i % 2) == 1);
            if (i > 0) chk("t2_rf_rd", rf_rd, ((i - 1) % 2 == 0) ? 1 : 2);
            step();
        end
        idle();
        chk("t2_rf_we_last", rf_we, 1);
        chk("t2_rf_rd_last", rf_rd, 2);
        chk("t2_rf_wd_last", rf_wd, 32'h22);
        step();

        // Scoreboard set and clear
        issue_valid = 1; issue_rd = 7;
        step(); idle();
        chk("t4_busy7_c1", busy[7], 1);
        step();
        step();
        req1_valid = 1; req1_rd = 7; req1_wd = 32'h77;
        step(); idle();
        chk("t4_rf_we_c4", rf_we, 1);
        chk("t4_rf_rd_c4", rf_rd, 7);
        chk("t4_busy7_c4", busy[7], 1);
        step();
        chk("t4_busy7_c5", busy[7], 0);

        // Set wins over a simultaneous clear; x0 is never busy
        issue_valid = 1; issue_rd = 9;
        step(); idle();
        req0_valid = 1; req0_rd = 9; req0_wd = 32'h99;
        step(); idle();
        issue_valid = 1; issue_rd = 9;
        chk("t5_rf_we", rf_we, 1);
        chk("t5_rf_rd", rf_rd, 9);
        step(); idle();
        chk("t5_busy9", busy[9], 1);
        issue_valid = 1; issue_rd = 0;
        step(); idle();
        chk("t5_busy0", busy[0], 0);
        chk("t5_busy9_held", busy[9], 1);

        // Asynchronous reset mid-cycle with a write pending
        req1_valid = 1; req1_rd = 9; req1_wd = 32'h9;
        issue_valid = 1; issue_rd = 5;
        step(); idle();
        req0_valid = 1; req0_rd = 3; req0_wd = 32'h33;
        issue_valid = 1; issue_rd = 7;
        step(); idle();
        chk("t6_rf_we_pre", rf_we, 1);
        chk("t6_rf_rd_pre", rf_rd, 3);
        chk("t6_busy_pre", busy, 32'h000000A0);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rf_we_async", rf_we, 0);
        chk("t6_busy_async", busy, 0);
        step();
        chk("t6_rf_we_held", rf_we, 0);
        reset = 1'b1;
        req0_valid = 1; req0_rd = 1; req0_wd = 32'hA1;
        req1_valid = 1; req1_rd = 2; req1_wd = 32'hB2;
        #1;
        chk("t6_req0_first", req0_ready, 1);
        chk("t6_req1_wait", req1_ready, 0);
        step(); idle();
        chk("t6_rf_we_post", rf_we, 1);
        chk("t6_rf_rd_post", rf_rd, 1);
        chk("t6_rf_wd_post", rf_wd, 32'hA1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
